// File: rtl/calendar_pkg.sv
// Shared widths, reset values, month constants, load FSM encoding and the
// days-in-month helper for the calendar tracker.
package calendar_pkg;

    localparam int CS_W   = 7;
    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HR_W   = 5;
    localparam int DATE_W = 5;
    localparam int MON_W  = 4;
    localparam int YEAR_W = 15;
    localparam int WDAY_W = 3;

    localparam logic [DATE_W-1:0] RESET_DATE    = 5'd1;
    localparam logic [MON_W-1:0]  RESET_MONTH   = 4'd1;
    localparam logic [WDAY_W-1:0] RESET_WEEKDAY = 3'd4;

    localparam logic [MON_W-1:0] MON_JAN = 4'd1;
    localparam logic [MON_W-1:0] MON_FEB = 4'd2;
    localparam logic [MON_W-1:0] MON_APR = 4'd4;
    localparam logic [MON_W-1:0] MON_JUN = 4'd6;
    localparam logic [MON_W-1:0] MON_SEP = 4'd9;
    localparam logic [MON_W-1:0] MON_NOV = 4'd11;
    localparam logic [MON_W-1:0] MON_DEC = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_COMMIT = 2'd2
    } load_state_e;

    function automatic logic [DATE_W-1:0] days_in_month(input logic [MON_W-1:0] month,
                                                        input logic leap);
        logic [DATE_W-1:0] dim;
        case (month)
            MON_FEB: dim = leap ? 5'd29 : 5'd28;
            MON_APR, MON_JUN, MON_SEP, MON_NOV: dim = 5'd30;
            default: dim = 5'd31;
        endcase
        return dim;
    endfunction

endpackage

// File: rtl/leap_year_check.sv
// Combinational Gregorian leap-year test for a 15-bit year.
module leap_year_check
    import calendar_pkg::*;
(
    input  logic [YEAR_W-1:0] year_i,
    output logic              leap_o
);

    logic div4_s;
    logic div100_s;
    logic div400_s;

    assign div4_s   = (year_i[1:0] == 2'd0);
    assign div100_s = ((year_i % 15'd100) == 15'd0);
    assign div400_s = ((year_i % 15'd400) == 15'd0);
    assign leap_o   = (div4_s && !div100_s) || div400_s;

endmodule

// File: rtl/calendar_tracker.sv
// Wall-clock and Gregorian calendar driven by the 100 Hz tick, with a
// three-state validated set-time/date load path.
module calendar_tracker
    import calendar_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100,
    parameter int RESET_YEAR    = 1970
) (
    input  logic              clockSignal,
    input  logic              reset,
    input  logic              tickEnable,
    input  logic              loadValid,
    output logic              loadReady,
    input  logic [HR_W-1:0]   loadHours,
    input  logic [MIN_W-1:0]  loadMinutes,
    input  logic [SEC_W-1:0]  loadSeconds,
    input  logic [DATE_W-1:0] loadDate,
    input  logic [MON_W-1:0]  loadMonth,
    input  logic [YEAR_W-1:0] loadYear,
    input  logic [WDAY_W-1:0] loadDay,
    output logic [CS_W-1:0]   centiseconds,
    output logic [SEC_W-1:0]  seconds,
    output logic [MIN_W-1:0]  minutes,
    output logic [HR_W-1:0]   hours,
    output logic [DATE_W-1:0] date,
    output logic [MON_W-1:0]  month,
    output logic [YEAR_W-1:0] year,
    output logic [WDAY_W-1:0] weekday,
    output logic              secondPulse,
    output logic              midnightPulse,
    output logic              loadDone,
    output logic              loadError
);

    localparam logic [CS_W-1:0]   CS_LAST    = CS_W'(TICKS_PER_SEC - 1);
    localparam logic [YEAR_W-1:0] YEAR_RESET = YEAR_W'(RESET_YEAR);

    load_state_e       state_q;
    logic              ready_q, done_q, error_q, valid_q;
    logic              sec_pulse_q, mid_pulse_q;
    logic [CS_W-1:0]   centi_q, centi_d;
    logic [SEC_W-1:0]  sec_q, sec_d;
    logic [MIN_W-1:0]  min_q, min_d;
    logic [HR_W-1:0]   hr_q, hr_d;
    logic [DATE_W-1:0] date_q, date_d;
    logic [MON_W-1:0]  mon_q, mon_d;
    logic [YEAR_W-1:0] year_q, year_d;
    logic [WDAY_W-1:0] wday_q, wday_d;
    logic              sec_tick_s, day_tick_s;

    logic [HR_W-1:0]   stg_hr_q;
    logic [MIN_W-1:0]  stg_min_q;
    logic [SEC_W-1:0]  stg_sec_q;
    logic [DATE_W-1:0] stg_date_q;
    logic [MON_W-1:0]  stg_mon_q;
    logic [YEAR_W-1:0] stg_year_q;
    logic [WDAY_W-1:0] stg_wday_q;

    logic              live_leap_s, stg_leap_s, load_ok_s;
    logic [DATE_W-1:0] live_dim_s;

    leap_year_check u_live_leap (.year_i(year_q),     .leap_o(live_leap_s));
    leap_year_check u_stg_leap  (.year_i(stg_year_q), .leap_o(stg_leap_s));

    assign live_dim_s = days_in_month(mon_q, live_leap_s);

    // Full single-cycle carry cascade from centiseconds up to year.
    always_comb begin
        centi_d    = centi_q;
        sec_d      = sec_q;
        min_d      = min_q;
        hr_d       = hr_q;
        date_d     = date_q;
        mon_d      = mon_q;
        year_d     = year_q;
        wday_d     = wday_q;
        sec_tick_s = 1'b0;
        day_tick_s = 1'b0;
        if (tickEnable) begin
            if (centi_q >= CS_LAST) begin
                centi_d    = 7'd0;
                sec_tick_s = 1'b1;
                if (sec_q >= 6'd59) begin
                    sec_d = 6'd0;
                    if (min_q >= 6'd59) begin
                        min_d = 6'd0;
                        if (hr_q >= 5'd23) begin
                            hr_d       = 5'd0;
                            day_tick_s = 1'b1;
                            wday_d     = (wday_q >= 3'd6) ? 3'd0 : wday_q + 3'd1;
                            if (date_q >= live_dim_s) begin
                                date_d = 5'd1;
                                if (mon_q >= MON_DEC) begin
                                    mon_d  = MON_JAN;
                                    year_d = year_q + 15'd1;
                                end else begin
                                    mon_d = mon_q + 4'd1;
                                end
                            end else begin
                                date_d = date_q + 5'd1;
                            end
                        end else begin
                            hr_d = hr_q + 5'd1;
                        end
                    end else begin
                        min_d = min_q + 6'd1;
                    end
                end else begin
                    sec_d = sec_q + 6'd1;
                end
            end else begin
                centi_d = centi_q + 7'd1;
            end
        end else begin
            centi_d = centi_q;
        end
    end

    // Staged load validity, judged against the staged year's leap status.
    always_comb begin
        load_ok_s = (stg_hr_q <= 5'd23) && (stg_min_q <= 6'd59) && (stg_sec_q <= 6'd59) &&
                    (stg_mon_q >= MON_JAN) && (stg_mon_q <= MON_DEC) &&
                    (stg_date_q >= 5'd1) &&
                    (stg_date_q <= days_in_month(stg_mon_q, stg_leap_s)) &&
                    (stg_wday_q <= 3'd6);
    end

    // Load FSM, staging registers and the live time/date state.
    always_ff @(posedge clockSignal) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            valid_q     <= 1'b0;
            sec_pulse_q <= 1'b0;
            mid_pulse_q <= 1'b0;
            stg_hr_q    <= 5'd0;
            stg_min_q   <= 6'd0;
            stg_sec_q   <= 6'd0;
            stg_date_q  <= 5'd0;
            stg_mon_q   <= 4'd0;
            stg_year_q  <= 15'd0;
            stg_wday_q  <= 3'd0;
            centi_q     <= 7'd0;
            sec_q       <= 6'd0;
            min_q       <= 6'd0;
            hr_q        <= 5'd0;
            date_q      <= RESET_DATE;
            mon_q       <= RESET_MONTH;
            year_q      <= YEAR_RESET;
            wday_q      <= RESET_WEEKDAY;
        end else begin
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            sec_pulse_q <= 1'b0;
            mid_pulse_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (loadValid) begin
                        stg_hr_q   <= loadHours;
                        stg_min_q  <= loadMinutes;
                        stg_sec_q  <= loadSeconds;
                        stg_date_q <= loadDate;
                        stg_mon_q  <= loadMonth;
                        stg_year_q <= loadYear;
                        stg_wday_q <= loadDay;
                        state_q    <= ST_CHECK;
                        ready_q    <= 1'b0;
                    end else begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                ST_CHECK: begin
                    valid_q <= load_ok_s;
                    state_q <= ST_COMMIT;
                    ready_q <= 1'b0;
                end
                ST_COMMIT: begin
                    done_q  <= valid_q;
                    error_q <= !valid_q;
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
            // A committing valid load overrides any coincident tick.
            if ((state_q == ST_COMMIT) && valid_q) begin
                centi_q <= 7'd0;
                sec_q   <= stg_sec_q;
                min_q   <= stg_min_q;
                hr_q    <= stg_hr_q;
                date_q  <= stg_date_q;
                mon_q   <= stg_mon_q;
                year_q  <= stg_year_q;
                wday_q  <= stg_wday_q;
            end else begin
                centi_q     <= centi_d;
                sec_q       <= sec_d;
                min_q       <= min_d;
                hr_q        <= hr_d;
                date_q      <= date_d;
                mon_q       <= mon_d;
                year_q      <= year_d;
                wday_q      <= wday_d;
                sec_pulse_q <= sec_tick_s;
                mid_pulse_q <= day_tick_s;
            end
        end
    end

    assign loadReady     = ready_q;
    assign loadDone      = done_q;
    assign loadError     = error_q;
    assign centiseconds  = centi_q;
    assign seconds       = sec_q;
    assign minutes       = min_q;
    assign hours         = hr_q;
    assign date          = date_q;
    assign month         = mon_q;
    assign year          = year_q;
    assign weekday       = wday_q;
    assign secondPulse   = sec_pulse_q;
    assign midnightPulse = mid_pulse_q;

endmodule

// File: tb/tb_calendar_tracker.sv
// Directed bench for calendar_tracker: tick cascade, leap rollovers, load
// validation, tick/commit collision and reset during CHECK.
module tb_calendar_tracker;

    logic        clockSignal = 1'b0;
    logic        reset, tickEnable, loadValid, loadReady;
    logic [4:0]  loadHours, loadDate, hours, date;
    logic [5:0]  loadMinutes, loadSeconds, seconds, minutes;
    logic [3:0]  loadMonth, month;
    logic [14:0] loadYear, year;
    logic [2:0]  loadDay, weekday;
    logic [6:0]  centiseconds;
    logic        secondPulse, midnightPulse, loadDone, loadError;

    int pass_cnt = 0;
    int total_cnt = 0;
    int sec_cnt = 0, mid_cnt = 0, done_cnt = 0, err_cnt = 0;
    int snap_sec, snap_mid, snap_done, snap_err;

    calendar_tracker #(.TICKS_PER_SEC(100), .RESET_YEAR(1970)) dut (
        .clockSignal(clockSignal), .reset(reset), .tickEnable(tickEnable),
        .loadValid(loadValid), .loadReady(loadReady),
        .loadHours(loadHours), .loadMinutes(loadMinutes), .loadSeconds(loadSeconds),
        .loadDate(loadDate), .loadMonth(loadMonth), .loadYear(loadYear), .loadDay(loadDay),
        .centiseconds(centiseconds), .seconds(seconds), .minutes(minutes), .hours(hours),
        .date(date), .month(month), .year(year), .weekday(weekday),
        .secondPulse(secondPulse), .midnightPulse(midnightPulse),
        .loadDone(loadDone), .loadError(loadError)
    );

    always #5 clockSignal = ~clockSignal;

    always @(posedge clockSignal) begin
        if (secondPulse === 1'b1)   sec_cnt  <= sec_cnt + 1;
        if (midnightPulse === 1'b1) mid_cnt  <= mid_cnt + 1;
        if (loadDone === 1'b1)      done_cnt <= done_cnt + 1;
        if (loadError === 1'b1)     err_cnt  <= err_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clockSignal); #1;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tickEnable = 1'b1;
            @(posedge clockSignal); #1;
        end
        tickEnable = 1'b0;
    endtask

    task automatic chk_time(input string tag, input int h, input int mi, input int s,
                            input int d, input int mo, input int y, input int wd);
        chk({tag, ".hours"},   32'(hours),   32'(h));
        chk({tag, ".minutes"}, 32'(minutes), 32'(mi));
        chk({tag, ".seconds"}, 32'(seconds), 32'(s));
        chk({tag, ".date"},    32'(date),    32'(d));
        chk({tag, ".month"},   32'(month),   32'(mo));
        chk({tag, ".year"},    32'(year),    32'(y));
        chk({tag, ".weekday"}, 32'(weekday), 32'(wd));
    endtask

    task automatic do_load(input string tag, input int h, input int mi, input int s,
                           input int d, input int mo, input int y, input int wd,
                           input bit tick_commit, input bit exp_ok);
        int guard = 0;
        while (loadReady !== 1'b1 && guard < 10) begin
            @(posedge clockSignal); #1;
            guard++;
        end
        chk({tag, ".ready_wait"}, 32'(loadReady), 32'd1);
        loadHours = 5'(h); loadMinutes = 6'(mi); loadSeconds = 6'(s);
        loadDate = 5'(d); loadMonth = 4'(mo); loadYear = 15'(y); loadDay = 3'(wd);
        loadValid = 1'b1;
        @(posedge clockSignal); #1;
        loadValid = 1'b0;
        chk({tag, ".ready_in_check"}, 32'(loadReady), 32'd0);
        @(posedge clockSignal); #1;
        tickEnable = tick_commit;
        @(posedge clockSignal); #1;
        tickEnable = 1'b0;
        chk({tag, ".loadDone"},  32'(loadDone),  32'(exp_ok));
        chk({tag, ".loadError"}, 32'(loadError), 32'(!exp_ok));
        chk({tag, ".ready_after"}, 32'(loadReady), 32'd1);
    endtask

    initial begin
        reset = 1'b1; tickEnable = 1'b0; loadValid = 1'b0;
        loadHours = 5'd0; loadMinutes = 6'd0; loadSeconds = 6'd0; loadDate = 5'd0;
        loadMonth = 4'd0; loadYear = 15'd0; loadDay = 3'd0;
        cycles(3);
        reset = 1'b0;
        cycles(1);

        // Reset state
        chk_time("reset", 0, 0, 0, 1, 1, 1970, 4);
        chk("reset.centi", 32'(centiseconds), 32'd0);
        chk("reset.ready", 32'(loadReady), 32'd1);
        chk("reset.secpulse", 32'(secondPulse), 32'd0);
        chk("reset.midpulse", 32'(midnightPulse), 32'd0);
        chk("reset.done", 32'(loadDone), 32'd0);

        // 99 ticks stay within the first second, the 100th carries
        snap_sec = sec_cnt;
        ticks(99);
        chk("cs99.centi", 32'(centiseconds), 32'd99);
        chk("cs99.seconds", 32'(seconds), 32'd0);
        ticks(1);
        chk("sec1.secpulse", 32'(secondPulse), 32'd1);
        cycles(2);
        chk("sec1.centi", 32'(centiseconds), 32'd0);
        chk("sec1.seconds", 32'(seconds), 32'd1);
        chk("sec1.pulse_count", 32'(sec_cnt - snap_sec), 32'd1);

        // Millennium rollover: full cascade with year carry
        do_load("y2k", 23, 59, 59, 31, 12, 1999, 5, 1'b0, 1'b1);
        chk_time("y2k.loaded", 23, 59, 59, 31, 12, 1999, 5);
        chk("y2k.centi", 32'(centiseconds), 32'd0);
        snap_mid = mid_cnt;
        ticks(100);
        cycles(2);
        chk_time("y2k.roll", 0, 0, 0, 1, 1, 2000, 6);
        chk("y2k.mid_count", 32'(mid_cnt - snap_mid), 32'd1);

        // February 28 rollover under the four leap rules
        do_load("feb2000", 23, 59, 59, 28, 2, 2000, 1, 1'b0, 1'b1);
        ticks(100);
        chk_time("feb2000.roll", 0, 0, 0, 29, 2, 2000, 2);
        do_load("feb1900", 23, 59, 59, 28, 2, 1900, 1, 1'b0, 1'b1);
        ticks(100);
        chk_time("feb1900.roll", 0, 0, 0, 1, 3, 1900, 2);
        do_load("feb2024", 23, 59, 59, 28, 2, 2024, 1, 1'b0, 1'b1);
        ticks(100);
        chk_time("feb2024.roll", 0, 0, 0, 29, 2, 2024, 2);
        do_load("feb2023", 23, 59, 59, 28, 2, 2023, 1, 1'b0, 1'b1);
        ticks(100);
        chk_time("feb2023.roll", 0, 0, 0, 1, 3, 2023, 2);

        // Rejected loads leave 00:00:00.00 1/3/2023 intact
        do_load("bad_feb29", 10, 0, 0, 29, 2, 2023, 1, 1'b0, 1'b0);
        chk_time("bad_feb29.keep", 0, 0, 0, 1, 3, 2023, 2);
        do_load("bad_hour24", 24, 0, 0, 1, 1, 2020, 1, 1'b0, 1'b0);
        chk_time("bad_hour24.keep", 0, 0, 0, 1, 3, 2023, 2);
        do_load("bad_month0", 10, 0, 0, 1, 0, 2020, 1, 1'b0, 1'b0);
        chk_time("bad_month0.keep", 0, 0, 0, 1, 3, 2023, 2);
        do_load("bad_apr31", 10, 0, 0, 31, 4, 2021, 1, 1'b0, 1'b0);
        chk_time("bad_apr31.keep", 0, 0, 0, 1, 3, 2023, 2);
        chk("bad.centi", 32'(centiseconds), 32'd0);

        // Tick during COMMIT: discarded for a valid load, applied for a rejected one
        do_load("commit_tick_ok", 12, 34, 56, 15, 6, 2022, 3, 1'b1, 1'b1);
        chk_time("commit_tick_ok.val", 12, 34, 56, 15, 6, 2022, 3);
        chk("commit_tick_ok.centi", 32'(centiseconds), 32'd0);
        do_load("commit_tick_bad", 25, 0, 0, 1, 1, 2022, 0, 1'b1, 1'b0);
        chk("commit_tick_bad.centi", 32'(centiseconds), 32'd1);
        chk("commit_tick_bad.hours", 32'(hours), 32'd12);

        // Year wraps from 32767 to 0
        do_load("ywrap", 23, 59, 59, 31, 12, 32767, 0, 1'b0, 1'b1);
        ticks(100);
        chk_time("ywrap.roll", 0, 0, 0, 1, 1, 0, 1);

        // Reset while the load sits in CHECK: no done/error pulse ever
        snap_done = done_cnt;
        snap_err  = err_cnt;
        loadHours = 5'd5; loadMinutes = 6'd6; loadSeconds = 6'd7; loadDate = 5'd8;
        loadMonth = 4'd9; loadYear = 15'd2010; loadDay = 3'd3;
        loadValid = 1'b1;
        @(posedge clockSignal); #1;
        loadValid = 1'b0;
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
        cycles(4);
        chk("rst_check.done_count", 32'(done_cnt - snap_done), 32'd0);
        chk("rst_check.err_count", 32'(err_cnt - snap_err), 32'd0);
        chk_time("rst_check.state", 0, 0, 0, 1, 1, 1970, 4);
        chk("rst_check.ready", 32'(loadReady), 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
